dice_roll_ctrl: RTL
===================

# dice_roll_ctrl

Roll sequencer for the dice display. It sits between the seven debounced die-select buttons and the digit counter/seven-segment datapath. It arbitrates button presses and latches the chosen die. It then drives load/step strobes to the digit counter: free-running spin while the button is held, a decelerating reveal after release, then result hold and a display-blank timeout.

## Interface
Parameters:
- TIMEOUT_TICKS, 960: ticks in SHOW before blanking (30 s at 32 Hz); 10-bit counter.
- SLOW_STEPS, 8: number of reveal steps after release.

Ports:
- clk  in  1  system clock, 32768 Hz.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  one-cycle pulse at 32 Hz from the prescaler.
- btn  in  7  debounced button levels; [0]=d4, [1]=d6, [2]=d8, [3]=d10, [4]=d12, [5]=d20, [6]=d100.
- load  out  1  one-cycle strobe: digit counter loads max value of die_sel.
- step  out  1  one-cycle strobe: digit counter decrements with wrap to max.
- die_sel  out  3  latched die index 0..6.
- show  out  1  display enable (0 = all digits blank).
- rolling  out  1  high in ARM, SPIN, SLOW.
- state  out  3  current FSM state, debug.

## Operation
- States: IDLE, ARM, SPIN, SLOW, SHOW, DIM.
- Press detect: btn registered into prev. new = btn & ~prev. prev resets to 7'h7F, so a button held through reset never triggers; a roll needs release then press.
- Arbitration: lowest set index of new wins. Simultaneous rises in the same cycle resolve to the lowest index.
- Accepted presses: IDLE, SHOW, DIM. Any press -> ARM; die_sel latched; load pulsed.
- Ignored presses: ARM, SPIN, SLOW. No state or die_sel change.
- ARM: exactly 1 cycle, then SPIN.
- SPIN: step=1 every clk cycle while btn[die_sel]=1; show=0. Other buttons are ignored.
  - Release of btn[die_sel] -> SLOW.
  - No spin length limit; wrap is handled by the datapath.
- SLOW: show=1, rolling=1; issues SLOW_STEPS steps.
  - Step k waits I[k] ticks; I = 1,1,2,2,3,4,6,8 (27 ticks total).
  - Interval counter clears on entry and after each step.
  - After the 8th step -> SHOW.
- SHOW: show=1, rolling=0; counts ticks. At TIMEOUT_TICKS -> DIM.
- DIM: show=0. A press -> ARM.
- IDLE: show=1, die_sel=0; leaves only on a press.
- Reset values: state=IDLE, load=0, step=0, die_sel=0, show=1, rolling=0, all counters 0.
- rst mid-operation: next cycle IDLE, no strobe emitted, regardless of state or buttons.

## Timing
- All outputs are registered.
- Rising edge sampled in cycle n -> ARM with load=1 in cycle n+1 -> SPIN in n+2, first step=1 in n+2.
- Release sampled in cycle m:
  - last SPIN step is in cycle m (step reflects btn registered, one-cycle latency);
  - SLOW from m+1, no step in m+1.
- SLOW: the tick completing an interval at cycle t -> step=1 in t+1.
- 8th step at cycle s -> SHOW at s+1.
- Timeout: the tick bringing the count to TIMEOUT_TICKS at cycle t -> DIM, show=0 at t+1.
- tick coinciding with a state transition is consumed by the new state only if that state counts ticks and has been entered; counters start at 0 on entry.
- load and step are never high in the same cycle.

## Configuration
- DICE_ROLL_ANIM_EN defined: SLOW phase as above.
- DICE_ROLL_ANIM_EN undefined: release in SPIN goes directly to SHOW (cycle m+1). The SLOW state and interval table are not compiled; the state encoding is unchanged.

## Structure
- Package dice_pkg:
  - state enum;
  - die index constants D4..D100;
  - SLOW_INTERVAL table (4-bit entries);
  - TIMEOUT_TICKS default.
- Sub-module rise_arbiter:
  - contains prev register, edge detect and lowest-index priority encoder;
  - outputs valid and idx[2:0].
- The FSM, interval counter, step counter and timeout counter live in dice_roll_ctrl.

## Test plan
- Reset with btn=7'h04 held, then hold 50 cycles -> no load, state stays IDLE. Release, then press btn[2] -> load in n+1, die_sel=2.
- btn[1] and btn[5] rise in the same cycle -> die_sel=1. Holding 100 cycles -> 100 step pulses; btn[5] release/press during SPIN -> no effect.
- Release after SPIN (anim on), tick every 1024 cycles -> exactly 8 steps at tick offsets 1,2,4,6,9,13,19,27, then SHOW; presses during SLOW ignored.
- In SHOW, 960 ticks -> show falls one cycle after the 960th tick. A press in DIM -> ARM with load pulse.
- rst asserted in SPIN and in SLOW -> IDLE next cycle, step=0, show=1, die_sel=0.
- Build without DICE_ROLL_ANIM_EN: release -> SHOW at m+1, zero steps after release.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll sequencer.
// The SLOW reveal table exists only when DICE_ROLL_ANIM_EN is defined.
package dice_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_SPIN = 3'd2,
    ST_SLOW = 3'd3,
    ST_SHOW = 3'd4,
    ST_DIM  = 3'd5
  } state_e;

  localparam logic [2:0] D4   = 3'd0;
  localparam logic [2:0] D6   = 3'd1;
  localparam logic [2:0] D8   = 3'd2;
  localparam logic [2:0] D10  = 3'd3;
  localparam logic [2:0] D12  = 3'd4;
  localparam logic [2:0] D20  = 3'd5;
  localparam logic [2:0] D100 = 3'd6;

  localparam int NUM_BTN               = 7;
  localparam int DEFAULT_TIMEOUT_TICKS = 960;

`ifdef DICE_ROLL_ANIM_EN
  // Ticks to wait before each reveal step; entry [0] is the first step.
  localparam logic [7:0][3:0] SLOW_INTERVAL = {4'd8, 4'd6, 4'd4, 4'd3,
                                               4'd2, 4'd2, 4'd1, 4'd1};
`endif

  function automatic logic show_of(input state_e s);
    return (s == ST_IDLE) || (s == ST_SLOW) || (s == ST_SHOW);
  endfunction

  function automatic logic rolling_of(input state_e s);
    return (s == ST_ARM) || (s == ST_SPIN) || (s == ST_SLOW);
  endfunction

endpackage

// File: rtl/rise_arbiter.sv
// Button rising-edge detector with lowest-index priority selection.
// prev resets to all-ones so buttons held through reset never fire.
module rise_arbiter
  import dice_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic               valid,
  output logic [2:0]         idx
);

  logic [NUM_BTN-1:0] prev_q;
  logic [NUM_BTN-1:0] prev_d;
  logic [NUM_BTN-1:0] new_w;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_edge
      assign new_w[gi] = btn[gi] & ~prev_q[gi];
    end
  endgenerate

  always_comb begin
    prev_d = btn;
    valid  = |new_w;
    idx    = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (new_w[i]) idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) prev_q <= '1;
    else     prev_q <= prev_d;
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: press arbitration, spin/reveal stepping, show timeout.
// Define DICE_ROLL_ANIM_EN to build the decelerating SLOW reveal phase.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
  parameter int SLOW_STEPS    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NUM_BTN-1:0] btn,
  output logic               load,
  output logic               step,
  output logic [2:0]         die_sel,
  output logic               show,
  output logic               rolling,
  output logic [2:0]         state
);

  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_TICKS - 1);

  logic       press_valid;
  logic [2:0] press_idx;

  state_e     state_q, state_d;
  logic       load_q, load_d;
  logic       step_q, step_d;
  logic [2:0] die_sel_q, die_sel_d;
  logic       show_q, show_d;
  logic       rolling_q, rolling_d;
  logic [9:0] timeout_cnt_q, timeout_cnt_d;
`ifdef DICE_ROLL_ANIM_EN
  localparam logic [3:0] LAST_STEP = 4'(SLOW_STEPS);
  logic [3:0] int_cnt_q, int_cnt_d;
  logic [3:0] step_cnt_q, step_cnt_d;
`else
  logic unused_slow_steps;
  assign unused_slow_steps = (SLOW_STEPS != 0);
`endif

  rise_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .valid (press_valid),
    .idx   (press_idx)
  );

  always_comb begin
    state_d       = state_q;
    load_d        = 1'b0;
    step_d        = 1'b0;
    die_sel_d     = die_sel_q;
    timeout_cnt_d = '0;
`ifdef DICE_ROLL_ANIM_EN
    int_cnt_d     = '0;
    step_cnt_d    = '0;
`endif
    case (state_q)
      ST_IDLE, ST_SHOW, ST_DIM: begin
        if (press_valid) begin
          state_d   = ST_ARM;
          die_sel_d = press_idx;
          load_d    = 1'b1;
        end else if (state_q == ST_SHOW) begin
          timeout_cnt_d = timeout_cnt_q;
          if (tick) begin
            if (timeout_cnt_q == TIMEOUT_LAST) state_d = ST_DIM;
            else timeout_cnt_d = timeout_cnt_q + 10'd1;
          end
        end
      end
      ST_ARM: begin
        state_d = ST_SPIN;
        step_d  = btn[die_sel_q];
      end
      ST_SPIN: begin
        if (btn[die_sel_q]) step_d = 1'b1;
`ifdef DICE_ROLL_ANIM_EN
        else state_d = ST_SLOW;
`else
        else state_d = ST_SHOW;
`endif
      end
`ifdef DICE_ROLL_ANIM_EN
      ST_SLOW: begin
        int_cnt_d  = int_cnt_q;
        step_cnt_d = step_cnt_q;
        // Leave one cycle after the final step strobe so it is seen in SLOW.
        if (step_cnt_q == LAST_STEP) begin
          state_d = ST_SHOW;
        end else if (tick) begin
          if (int_cnt_q + 4'd1 == SLOW_INTERVAL[step_cnt_q[2:0]]) begin
            step_d     = 1'b1;
            int_cnt_d  = '0;
            step_cnt_d = step_cnt_q + 4'd1;
          end else begin
            int_cnt_d = int_cnt_q + 4'd1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    show_d    = show_of(state_d);
    rolling_d = rolling_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      load_q        <= 1'b0;
      step_q        <= 1'b0;
      die_sel_q     <= '0;
      show_q        <= 1'b1;
      rolling_q     <= 1'b0;
      timeout_cnt_q <= '0;
`ifdef DICE_ROLL_ANIM_EN
      int_cnt_q     <= '0;
      step_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      load_q        <= load_d;
      step_q        <= step_d;
      die_sel_q     <= die_sel_d;
      show_q        <= show_d;
      rolling_q     <= rolling_d;
      timeout_cnt_q <= timeout_cnt_d;
`ifdef DICE_ROLL_ANIM_EN
      int_cnt_q     <= int_cnt_d;
      step_cnt_q    <= step_cnt_d;
`endif
    end
  end

  assign load    = load_q;
  assign step    = step_q;
  assign die_sel = die_sel_q;
  assign show    = show_q;
  assign rolling = rolling_q;
  assign state   = state_q;

endmodule
